// File: rtl/mem_wb_pipe_bank.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_pipe_bank
// Description : STAGES-deep MEM->WB pipeline register bank with freeze, flush,
//               write-back data select and dest-match hit flags.
//               Optional frozen-cycle counter enabled by MEM_WB_STALL_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_pipe_bank #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 4,
    parameter int STAGES = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              valid_in,
    input  logic              wb_en_in,
    input  logic              mem_r_en_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] mem_read_in,
    input  logic [DEST_W-1:0] dest_in,
    input  logic [DEST_W-1:0] src1,
    input  logic [DEST_W-1:0] src2,
`ifdef MEM_WB_STALL_CNT_EN
    output logic [CNT_W-1:0]  stall_cnt,
`endif
    output logic              valid,
    output logic              wb_en,
    output logic              mem_r_en,
    output logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] mem_read,
    output logic [DEST_W-1:0] dest,
    output logic [DATA_W-1:0] wb_value,
    output logic              hit1,
    output logic              hit2
);

    localparam int c_last = STAGES - 1;

    generate
        if (STAGES < 1) begin : g_bad_stages
            $error("mem_wb_pipe_bank: STAGES must be >= 1");
        end
    endgenerate

    logic [STAGES-1:0]             r_valid;
    logic [STAGES-1:0]             r_wb_en;
    logic [STAGES-1:0]             r_mem_r_en;
    logic [STAGES-1:0][DATA_W-1:0] r_alu;
    logic [STAGES-1:0][DATA_W-1:0] r_mrd;
    logic [STAGES-1:0][DEST_W-1:0] r_dest;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid    <= '0;
            r_wb_en    <= '0;
            r_mem_r_en <= '0;
            r_alu      <= '0;
            r_mrd      <= '0;
            r_dest     <= '0;
        end else begin
            if (!freeze) begin
                r_valid[0]    <= valid_in;
                r_wb_en[0]    <= wb_en_in;
                r_mem_r_en[0] <= mem_r_en_in;
                r_alu[0]      <= alu_result_in;
                r_mrd[0]      <= mem_read_in;
                r_dest[0]     <= dest_in;
                for (int k = 1; k < STAGES; k++) begin
                    r_valid[k]    <= r_valid[k-1];
                    r_wb_en[k]    <= r_wb_en[k-1];
                    r_mem_r_en[k] <= r_mem_r_en[k-1];
                    r_alu[k]      <= r_alu[k-1];
                    r_mrd[k]      <= r_mrd[k-1];
                    r_dest[k]     <= r_dest[k-1];
                end
            end
            // Flush overrides the freeze hold on the valid bits only.
            if (flush) begin
                r_valid <= '0;
            end
        end
    end

    logic w_mem_r_en;
    assign w_mem_r_en = r_valid[c_last] & r_mem_r_en[c_last];

    assign valid      = r_valid[c_last];
    assign wb_en      = r_valid[c_last] & r_wb_en[c_last];
    assign mem_r_en   = w_mem_r_en;
    assign alu_result = r_alu[c_last];
    assign mem_read   = r_mrd[c_last];
    assign dest       = r_dest[c_last];
    assign wb_value   = w_mem_r_en ? r_mrd[c_last] : r_alu[c_last];

    logic w_hit1;
    logic w_hit2;

    always_comb begin
        w_hit1 = 1'b0;
        w_hit2 = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            w_hit1 = w_hit1 | (r_valid[k] & r_wb_en[k] & (r_dest[k] == src1));
            w_hit2 = w_hit2 | (r_valid[k] & r_wb_en[k] & (r_dest[k] == src2));
        end
    end

    assign hit1 = w_hit1;
    assign hit2 = w_hit2;

`ifdef MEM_WB_STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (freeze && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_pipe_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_wb_pipe_bank
// Description : Directed self-checking bench for mem_wb_pipe_bank, using a
//               3-stage and a 2-stage (CNT_W=2) instance on shared inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_pipe_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        freeze = 1'b0;
    logic        flush = 1'b0;
    logic        valid_in = 1'b0;
    logic        wb_en_in = 1'b0;
    logic        mem_r_en_in = 1'b0;
    logic [31:0] alu_result_in = '0;
    logic [31:0] mem_read_in = '0;
    logic [3:0]  dest_in = '0;
    logic [3:0]  src1 = '0;
    logic [3:0]  src2 = '0;

    logic        v3, we3, mr3, h13, h23;
    logic [31:0] alu3, mrd3, wbv3;
    logic [3:0]  d3;
    logic        v2, we2, mr2, h12, h22;
    logic [31:0] alu2, mrd2, wbv2;
    logic [3:0]  d2;
`ifdef MEM_WB_STALL_CNT_EN
    logic [15:0] cnt3;
    logic [1:0]  cnt2;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_wb_pipe_bank #(.DATA_W(32), .DEST_W(4), .STAGES(3), .CNT_W(16)) dut3 (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .valid_in(valid_in), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
        .alu_result_in(alu_result_in), .mem_read_in(mem_read_in),
        .dest_in(dest_in), .src1(src1), .src2(src2),
`ifdef MEM_WB_STALL_CNT_EN
        .stall_cnt(cnt3),
`endif
        .valid(v3), .wb_en(we3), .mem_r_en(mr3), .alu_result(alu3),
        .mem_read(mrd3), .dest(d3), .wb_value(wbv3), .hit1(h13), .hit2(h23)
    );

    mem_wb_pipe_bank #(.DATA_W(32), .DEST_W(4), .STAGES(2), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .valid_in(valid_in), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
        .alu_result_in(alu_result_in), .mem_read_in(mem_read_in),
        .dest_in(dest_in), .src1(src1), .src2(src2),
`ifdef MEM_WB_STALL_CNT_EN
        .stall_cnt(cnt2),
`endif
        .valid(v2), .wb_en(we2), .mem_r_en(mr2), .alu_result(alu2),
        .mem_read(mrd2), .dest(d2), .wb_value(wbv2), .hit1(h12), .hit2(h22)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one slot, clock it in, then settle 1 time unit past the edge.
    task automatic push(input logic v, input logic we, input logic mr,
                        input logic [31:0] alu, input logic [31:0] mrd,
                        input logic [3:0] d);
        valid_in      = v;
        wb_en_in      = we;
        mem_r_en_in   = mr;
        alu_result_in = alu;
        mem_read_in   = mrd;
        dest_in       = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_valid", {31'b0, v3}, 32'h0);
        chk("rst_alu", alu3, 32'h0);
        chk("rst_wb_en", {31'b0, we3}, 32'h0);
        chk("rst_valid2", {31'b0, v2}, 32'h0);
        rst = 1'b1;

        // Three-stage latency: A appears after its third edge
        src1 = 4'd3;
        src2 = 4'd9;
        push(1'b1, 1'b1, 1'b0, 32'h11, 32'h0, 4'd1);
        chk("lat_empty1", {31'b0, v3}, 32'h0);
        push(1'b1, 1'b1, 1'b0, 32'h22, 32'h0, 4'd2);
        chk("lat_empty2", {31'b0, v3}, 32'h0);
        push(1'b1, 1'b1, 1'b0, 32'h33, 32'h0, 4'd3);
        chk("lat_A_valid", {31'b0, v3}, 32'h1);
        chk("lat_A_alu", alu3, 32'h11);
        chk("lat_A_wb_en", {31'b0, we3}, 32'h1);
        chk("hit_stage0", {31'b0, h13}, 32'h1);
        chk("nohit", {31'b0, h23}, 32'h0);

        // Freeze two cycles; presented slot must be ignored
        freeze = 1'b1;
        push(1'b1, 1'b1, 1'b0, 32'h99, 32'h0, 4'd9);
        chk("frz1_alu", alu3, 32'h11);
        push(1'b1, 1'b1, 1'b0, 32'h99, 32'h0, 4'd9);
        chk("frz2_alu", alu3, 32'h11);
        chk("frz2_valid", {31'b0, v3}, 32'h1);
`ifdef MEM_WB_STALL_CNT_EN
        chk("frz_cnt", {16'b0, cnt3}, 32'h2);
`endif
        freeze = 1'b0;
        push(1'b1, 1'b1, 1'b0, 32'h44, 32'h0, 4'd4);
        chk("resume_B", alu3, 32'h22);
        push(1'b1, 1'b1, 1'b0, 32'h55, 32'h0, 4'd5);
        chk("resume_C", alu3, 32'h33);
        push(1'b1, 1'b1, 1'b0, 32'h66, 32'h0, 4'd6);
        chk("resume_D", alu3, 32'h44);
        chk("resume_D_dest", {28'b0, d3}, 32'h4);

        // Flush with freeze on a full pipe
        src1 = 4'd4;
        src2 = 4'd6;
        #1;
        chk("prefl_hit1", {31'b0, h13}, 32'h1);
        chk("prefl_hit2", {31'b0, h23}, 32'h1);
        freeze = 1'b1;
        flush  = 1'b1;
        push(1'b1, 1'b1, 1'b0, 32'h77, 32'h0, 4'd4);
        chk("flush_valid", {31'b0, v3}, 32'h0);
        chk("flush_wb_en", {31'b0, we3}, 32'h0);
        chk("flush_hit1", {31'b0, h13}, 32'h0);
        chk("flush_hit2", {31'b0, h23}, 32'h0);
`ifdef MEM_WB_STALL_CNT_EN
        chk("flush_cnt", {16'b0, cnt3}, 32'h3);
`endif
        freeze = 1'b0;
        flush  = 1'b0;

        // Two-stage hit flags and load write-back select
        src1 = 4'd5;
        src2 = 4'd7;
        push(1'b1, 1'b0, 1'b1, 32'h1000, 32'hBEEF, 4'd7);
        push(1'b1, 1'b1, 1'b0, 32'h2000, 32'h0, 4'd5);
        chk("s2_valid", {31'b0, v2}, 32'h1);
        chk("s2_wb_en", {31'b0, we2}, 32'h0);
        chk("s2_mem_r_en", {31'b0, mr2}, 32'h1);
        chk("s2_wb_value", wbv2, 32'hBEEF);
        chk("s2_dest", {28'b0, d2}, 32'h7);
        chk("s2_hit1", {31'b0, h12}, 32'h1);
        chk("s2_hit2", {31'b0, h22}, 32'h0);
        push(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
        chk("s2_alu_sel", wbv2, 32'h2000);
        chk("s2_wb_en_y", {31'b0, we2}, 32'h1);
        chk("s3_load_sel", wbv3, 32'hBEEF);
        chk("s3_mem_r_en", {31'b0, mr3}, 32'h1);

        // Asynchronous reset mid-stream
        push(1'b1, 1'b1, 1'b0, 32'h1234, 32'h0, 4'd2);
        push(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
        push(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
        chk("pre_rst_alu", alu3, 32'h1234);
        chk("pre_rst_valid", {31'b0, v3}, 32'h1);
        rst = 1'b0;
        #2;
        chk("arst_valid", {31'b0, v3}, 32'h0);
        chk("arst_alu", alu3, 32'h0);
        chk("arst_wb_en", {31'b0, we3}, 32'h0);
        chk("arst_wb_value", wbv3, 32'h0);
        chk("arst_dest", {28'b0, d3}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Counter saturation on the CNT_W=2 instance
        freeze = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            push(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
`ifdef MEM_WB_STALL_CNT_EN
            chk("sat_cnt2", {30'b0, cnt2}, (i < 3) ? i : 3);
            chk("cnt3", {16'b0, cnt3}, i);
`endif
        end
        freeze = 1'b0;
        chk("sat_valid", {31'b0, v3}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
